hazard_fwd_unit: RTL
====================

# hazard_fwd_unit

Forwarding and load-use hazard controller for the 5-stage pipeline, sitting directly upstream of the EXE-stage operand multiplexers.
- Tracks the destination register and write/load flags of the instructions in EXE and MEM with its own shadow pipeline registers.
- Compares them against the ID-stage source registers and drives the 2-bit operand selects (`fwda`, `fwdb`) plus a one-cycle load-use `stall`.

## Interface
Parameters:
- `AW`, 5, register-address width.
- `CNT_W`, 32, width of statistics counters (used only when statistics are compiled in).

Ports:
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `clrn` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID stage holds a real instruction.
- `id_rs` in AW: source A register number.
- `id_rt` in AW: source B register number.
- `id_use_rs` in 1: instruction reads rs.
- `id_use_rt` in 1: instruction reads rt.
- `id_rn` in AW: destination register of the ID instruction.
- `id_wreg` in 1: ID instruction writes the register file.
- `id_m2reg` in 1: ID instruction is a load (result comes from data memory).
- `flush` in 1: ID instruction is squashed (taken branch/jump); it enters EXE as a bubble.
- `fwda` out 2: operand A select. 00 = qa, 01 = EXE ALU result r, 10 = MEM ALU result mr, 11 = memory data mdo.
- `fwdb` out 2: operand B select, same encoding.
- `stall` out 1: freeze PC and IF/ID; insert a bubble into EXE.
- `stat_stalls` out CNT_W: present only with `HAZARD_FWD_STATS_EN`.
- `stat_fwds` out CNT_W: present only with `HAZARD_FWD_STATS_EN`.

## Operation
Shadow state:
- EXE slot: `ern`, `ewreg`, `em2reg`.
- MEM slot: `mrn`, `mwreg`, `mm2reg`.

Per-cycle update:
- MEM slot <= EXE slot, unconditionally.
- EXE slot <= ID fields when `id_valid & ~stall & ~flush`.
- Otherwise EXE slot <= bubble: `ewreg=0`, `em2reg=0`, `ern=0`.

Match definitions:
- hitE(x) = `ewreg & ern!=0 & ern==x`.
- hitM(x) = `mwreg & mrn!=0 & mrn==x`.
- Register 0 is never a forwarding source.

Operand select `fwda` (computed from `id_rs`; `fwdb` is identical using `id_rt`):
- 01 if hitE(rs) and `em2reg=0`.
- else 10 if hitM(rs) and `mm2reg=0`.
- else 11 if hitM(rs) and `mm2reg=1`.
- else 00.
- EXE has priority over MEM (youngest producer wins).

Stall:
- `stall` = `id_valid & ~flush & em2reg & ((id_use_rs & hitE(id_rs)) | (id_use_rt & hitE(id_rt)))`.
- A load in EXE cannot forward. A select of 01 against a load in EXE is never produced; the stall resolves it.
- On the cycle after a stall, the load sits in MEM and select 11 applies.

Boundary rules:
- Unused operands (`id_use_x=0`) force that select to 00 and are excluded from stall.
- `id_valid=0` forces both selects to 00 and `stall` to 0.
- `flush` and a load-use hit in the same cycle: `stall`=0; the bubble comes from the flush.
- Back-to-back stalls are impossible: the stall's bubble clears `em2reg`.

## Timing
- `fwda`, `fwdb`, `stall`: combinational from current ID inputs and registered slots. Valid in the same cycle as ID inputs, zero latency.
- Slot update latency: 1 cycle ID->EXE, 1 cycle EXE->MEM.
- `clrn` low: both slots cleared to bubble immediately. `fwda=fwdb=00`, `stall=0`, stat counters 0.
- Reset asserted mid-stall: the stall drops immediately and no held state survives.
- First edge after `clrn` rises: normal update.

## Configuration
`HAZARD_FWD_STATS_EN` defined:
- `stat_stalls` increments on every cycle with `stall=1`.
- `stat_fwds` increments on every cycle where `fwda!=00` or `fwdb!=00`. Increment is 1 per cycle, not per operand.
- Both counters saturate at all-ones and reset to 0.

`HAZARD_FWD_STATS_EN` undefined:
- Counters and ports are absent.
- Behaviour is otherwise identical.

## Structure
- Shared package holds:
  - select encodings `FWD_QX=2'b00`, `FWD_R=2'b01`, `FWD_MR=2'b10`, `FWD_MDO=2'b11`;
  - `AW`;
  - a packed slot type {rn, wreg, m2reg};
  - the bubble constant.
- One sub-module `fwd_sel`: combinational select for one operand. Inputs: src, use, valid, both slots. Instantiated twice, for A and B.

## Test plan
- ALU dependence, EXE: EXE slot rn=5, wreg=1, m2reg=0; ID rs=5, use_rs=1 -> `fwda=01`, `stall=0`.
- ALU dependence, MEM: MEM slot rn=7, wreg=1, m2reg=0, EXE not matching; ID rt=7 -> `fwdb=10`.
- Load-use: EXE load rn=3; ID rs=3 -> `stall=1`. Next cycle: EXE bubble, MEM load rn=3 -> `fwda=11`, `stall=0`.
- Priority and r0:
  - EXE rn=4 and MEM rn=4 both writing -> select 01.
  - Any slot with rn=0, ID rs=0 -> select 00.
- Flush with load-use: EXE load rn=3, ID rs=3, `flush=1` -> `stall=0`; next cycle EXE slot is a bubble.
- Reset mid-operation: assert `clrn=0` while `stall=1` -> `stall` and selects are 0 without a clock edge. With `HAZARD_FWD_STATS_EN`, counters read 0.

Source files
------------

// File: rtl/hazard_fwd_unit_pkg.sv
// hazard_fwd_unit_pkg: select encodings, register-address width and the shadow slot type
package hazard_fwd_unit_pkg;
    localparam int AW = 5;
    localparam logic [1:0] FWD_QX  = 2'b00;
    localparam logic [1:0] FWD_R   = 2'b01;
    localparam logic [1:0] FWD_MR  = 2'b10;
    localparam logic [1:0] FWD_MDO = 2'b11;
    typedef struct packed {
        logic [AW-1:0] rn;
        logic          wreg;
        logic          m2reg;
    } slot_t;
    localparam slot_t BUBBLE = '0;
endpackage

// File: rtl/hazard_fwd_unit_fwd_sel.sv
// fwd_sel: operand select for one ID source against the EXE and MEM shadow slots
module fwd_sel
    import hazard_fwd_unit_pkg::*;
(
    input  logic [AW-1:0] i_src,
    input  logic          i_use,
    input  logic          i_valid,
    input  slot_t         i_e,
    input  slot_t         i_m,
    output logic [1:0]    o_sel,
    output logic          o_load_use
);
    logic w_hit_e;
    logic w_hit_m;
    assign w_hit_e = i_valid & i_use & i_e.wreg & (i_e.rn != '0) & (i_e.rn == i_src);
    assign w_hit_m = i_valid & i_use & i_m.wreg & (i_m.rn != '0) & (i_m.rn == i_src);
    // a load in EXE never forwards; the stall covers it
    assign o_sel = (w_hit_e & ~i_e.m2reg) ? FWD_R :
                   w_hit_m ? (i_m.m2reg ? FWD_MDO : FWD_MR) : FWD_QX;
    assign o_load_use = w_hit_e & i_e.m2reg;
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: forwarding selects and load-use stall for the EXE operand muxes.
// Optional saturating statistics counters under HAZARD_FWD_STATS_EN.
module hazard_fwd_unit #(
    parameter int AW = 5
`ifdef HAZARD_FWD_STATS_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [AW-1:0] id_rn,
    input  logic          id_wreg,
    input  logic          id_m2reg,
    input  logic          flush,
    output logic [1:0]    fwda,
    output logic [1:0]    fwdb,
    output logic          stall
`ifdef HAZARD_FWD_STATS_EN
    , output logic [CNT_W-1:0] stat_stalls
    , output logic [CNT_W-1:0] stat_fwds
`endif
);
    import hazard_fwd_unit_pkg::*;
    slot_t r_e;
    slot_t r_m;
    logic  w_lu_a;
    logic  w_lu_b;
    fwd_sel u_sel_a (
        .i_src(id_rs), .i_use(id_use_rs), .i_valid(id_valid), .i_e(r_e), .i_m(r_m),
        .o_sel(fwda), .o_load_use(w_lu_a)
    );
    fwd_sel u_sel_b (
        .i_src(id_rt), .i_use(id_use_rt), .i_valid(id_valid), .i_e(r_e), .i_m(r_m),
        .o_sel(fwdb), .o_load_use(w_lu_b)
    );
    // a same-cycle flush already supplies the bubble
    assign stall = (w_lu_a | w_lu_b) & ~flush;
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_e <= BUBBLE;
            r_m <= BUBBLE;
        end else begin
            r_m <= r_e;
            r_e <= (id_valid & ~stall & ~flush) ?
                   slot_t'{rn: id_rn, wreg: id_wreg, m2reg: id_m2reg} : BUBBLE;
        end
    end
`ifdef HAZARD_FWD_STATS_EN
    logic [CNT_W-1:0] r_stat_stalls;
    logic [CNT_W-1:0] r_stat_fwds;
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_stat_stalls <= '0;
            r_stat_fwds   <= '0;
        end else begin
            if (stall && !(&r_stat_stalls)) r_stat_stalls <= r_stat_stalls + CNT_W'(1);
            if (((fwda != FWD_QX) || (fwdb != FWD_QX)) && !(&r_stat_fwds))
                r_stat_fwds <= r_stat_fwds + CNT_W'(1);
        end
    end
    assign stat_stalls = r_stat_stalls;
    assign stat_fwds   = r_stat_fwds;
`endif
endmodule
